// File: rtl/req_onehot_arbiter.sv
// req_onehot_arbiter
//   Synchronizes eight asynchronous request lines, captures their rising edges
//   into a pending register and grants one pending line at a time, round-robin,
//   as a strictly one-hot word under a valid/ready handshake.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   req    in   [N-1:0] asynchronous level requests; each rising edge is one event
//   rdy    in   downstream ready; transfer when vld && rdy at a clk edge
//   d      out  [N-1:0] one-hot grant word, zero whenever vld is low
//   vld    out  d holds a valid grant
//   pend   out  [N-1:0] pending-event register
//   ovf    out  sticky: an event arrived on a line that was already pending
module req_onehot_arbiter #(
   parameter int unsigned N           = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         rdy,
   output logic [N-1:0] d,
   output logic         vld,
   output logic [N-1:0] pend,
   output logic         ovf
);

   localparam int unsigned PTR_W = $clog2(N);
   localparam logic [N-1:0] LINE0 = N'(1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [N-1:0]       sync_q [SYNC_STAGES];
   logic [N-1:0]       prev_q;
   logic [N-1:0]       pend_q, pend_d;
   logic [N-1:0]       d_q, d_d;
   logic               vld_q, vld_d;
   logic               ovf_q, ovf_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;

   logic [N-1:0]       rise;
   logic [N-1:0]       clr;
   logic               sel_found;
   logic [PTR_W-1:0]   sel_idx;
   logic [PTR_W-1:0]   gnt_idx;

   // Request synchronizer chain plus edge-detect history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
         prev_q <= '0;
      end else begin
         sync_q[0] <= req;
         for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

   // Round-robin pick: first pending line scanning upward from ptr, wrapping
   // naturally through the PTR_W-bit add
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = ptr_q;
      for (int unsigned k = 0; k < N; k++) begin
         logic [PTR_W-1:0] cand;
         cand = ptr_q + PTR_W'(k);
         if (!sel_found && pend_q[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   // Index of the line currently granted
   always_comb begin
      gnt_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (d_q[i]) begin
            gnt_idx = PTR_W'(i);
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (sel_found) state_d = GRANT;
         GRANT:   if (rdy)       state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM output / datapath next values
   always_comb begin
      d_d   = d_q;
      vld_d = vld_q;
      ptr_d = ptr_q;
      clr   = '0;
      unique case (state_q)
         IDLE: begin
            if (sel_found) begin
               d_d   = LINE0 << sel_idx;
               vld_d = 1'b1;
            end else begin
               d_d   = '0;
               vld_d = 1'b0;
            end
         end
         GRANT: begin
            // Held stable under backpressure; released only on acceptance
            if (rdy) begin
               clr   = d_q;
               ptr_d = gnt_idx + PTR_W'(1);
               d_d   = '0;
               vld_d = 1'b0;
            end
         end
         default: begin
            d_d   = '0;
            vld_d = 1'b0;
         end
      endcase
      // A new rise on the line being cleared survives (set wins, no overflow)
      pend_d = (pend_q & ~clr) | rise;
      ovf_d  = ovf_q | (|(rise & pend_q & ~clr));
   end

   // Registered outputs and arbitration state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         d_q    <= '0;
         vld_q  <= 1'b0;
         ovf_q  <= 1'b0;
         ptr_q  <= '0;
      end else begin
         pend_q <= pend_d;
         d_q    <= d_d;
         vld_q  <= vld_d;
         ovf_q  <= ovf_d;
         ptr_q  <= ptr_d;
      end
   end

   assign d    = d_q;
   assign vld  = vld_q;
   assign pend = pend_q;
   assign ovf  = ovf_q;

   // Handshake invariants seen by the encoder
   a_onehot: assert property (@(posedge clk) disable iff (!rst_n) vld |-> $onehot(d));
   a_zero:   assert property (@(posedge clk) disable iff (!rst_n) !vld |-> (d == '0));
   a_pend:   assert property (@(posedge clk) disable iff (!rst_n) vld |-> (|(d & pend)));
   a_hold:   assert property (@(posedge clk) disable iff (!rst_n)
                              (vld && !rdy) |=> (vld && $stable(d)));

endmodule

// File: tb/tb_req_onehot_arbiter.sv
// Testbench for req_onehot_arbiter: directed scenarios plus random traffic,
// checked against a cycle-level behavioural model and a grant scoreboard.
module tb_req_onehot_arbiter;

   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic       rdy;
   logic [7:0] d;
   logic       vld;
   logic [7:0] pend;
   logic       ovf;

   always #5 clk = ~clk;

   req_onehot_arbiter #(.N(8), .SYNC_STAGES(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .rdy   (rdy),
      .d     (d),
      .vld   (vld),
      .pend  (pend),
      .ovf   (ovf)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: req history, pending set, pointer, outstanding grant
   bit [7:0]   m_hist [0:S];
   bit [7:0]   m_pend;
   bit [7:0]   m_rise;
   bit [7:0]   m_clr;
   bit [7:0]   m_old;
   bit         m_ovf;
   bit         m_g;
   bit         m_found;
   int         m_ptr;
   int         m_gidx;
   logic [7:0] exp_q[$];
   logic [7:0] xfer_log[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j <= S; j++) m_hist[j] = '0;
         m_pend = '0;
         m_ovf  = 1'b0;
         m_g    = 1'b0;
         m_ptr  = 0;
         m_gidx = 0;
         exp_q.delete();
      end else begin
         // An event is a req that was sampled high S edges ago and low S+1 ago
         m_rise = m_hist[S-1] & ~m_hist[S];
         m_old  = m_pend;
         m_clr  = '0;
         if (!m_g) begin
            m_found = 1'b0;
            for (int k = 0; k < 8; k++) begin
               int i;
               i = (m_ptr + k) % 8;
               if (!m_found && m_old[i]) begin
                  m_found = 1'b1;
                  m_gidx  = i;
               end
            end
            if (m_found) begin
               m_g = 1'b1;
               exp_q.push_back(8'(1 << m_gidx));
            end
         end else if (rdy) begin
            m_clr = 8'(1 << m_gidx);
            m_ptr = (m_gidx + 1) % 8;
            m_g   = 1'b0;
         end
         if ((m_rise & m_old & ~m_clr) != 0) m_ovf = 1'b1;
         m_pend = (m_old & ~m_clr) | m_rise;
         for (int j = S; j > 0; j--) m_hist[j] = m_hist[j-1];
         m_hist[0] = req;
      end
   end

   // Monitor: per-cycle state comparison and scoreboard pop on each transfer
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("vld", 8'(vld), 8'(m_g));
         chk("d", d, m_g ? 8'(1 << m_gidx) : 8'h00);
         chk("pend", pend, m_pend);
         chk("ovf", 8'(ovf), 8'(m_ovf));
         if (vld === 1'b1 && rdy === 1'b1) begin
            xfer_log.push_back(d);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL xfer_unexpected: got %h expected none at %0t", d, $time);
            end else begin
               chk("xfer_d", d, exp_q.pop_front());
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      rdy   = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(4);
   endtask

   task automatic wait_vld(input int maxc);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < maxc && !ok; i++) begin
         @(negedge clk);
         if (vld === 1'b1) ok = 1'b1;
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_vld: got timeout expected vld=1 at %0t", $time);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] nxt;
      int         cnt;

      // Reset with all requests high
      rst_n = 1'b0;
      req   = 8'hFF;
      rdy   = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_d", d, 8'h00);
      chk("rst_vld", 8'(vld), 8'h00);
      chk("rst_pend", pend, 8'h00);
      chk("rst_ovf", 8'(ovf), 8'h00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req   = '0;
      tick(3);
      req = 8'h20;
      tick(1);
      req = '0;
      tick(2);
      @(negedge clk);
      chk("lat_pend", pend, 8'h20);
      chk("lat_vld0", 8'(vld), 8'h00);
      @(negedge clk);
      chk("lat_vld1", 8'(vld), 8'h01);
      chk("lat_d", d, 8'h20);
      tick(4);

      // Several lines at once, rdy held high
      do_reset();
      xfer_log.delete();
      rdy = 1'b1;
      req = 8'h52;
      tick(1);
      req = '0;
      tick(20);
      @(negedge clk);
      chk("multi_pend", pend, 8'h00);
      chk("multi_cnt", 8'(xfer_log.size()), 8'd3);
      if (xfer_log.size() >= 3) begin
         chk("multi_g0", xfer_log[0], 8'h02);
         chk("multi_g1", xfer_log[1], 8'h10);
         chk("multi_g2", xfer_log[2], 8'h40);
      end

      // Backpressure with a new request arriving under a held grant
      do_reset();
      xfer_log.delete();
      req = 8'h08;
      tick(1);
      req = '0;
      wait_vld(10);
      tick(1);
      req = 8'h01;
      tick(1);
      req = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_d", d, 8'h08);
         chk("bp_vld", 8'(vld), 8'h01);
      end
      chk("bp_pend", pend, 8'h09);
      @(posedge clk);
      #1;
      rdy = 1'b1;
      tick(8);
      chk("bp_cnt", 8'(xfer_log.size()), 8'd2);
      if (xfer_log.size() >= 2) chk("bp_wrap", xfer_log[1], 8'h01);

      // Fairness: all lines pending, each re-requested after its transfer
      do_reset();
      xfer_log.delete();
      rdy = 1'b1;
      req = 8'hFF;
      tick(1);
      req = '0;
      cnt = 0;
      while (xfer_log.size() < 16 && cnt < 300) begin
         @(negedge clk);
         nxt = (vld === 1'b1 && rdy === 1'b1) ? d : 8'h00;
         @(posedge clk);
         #1;
         req = nxt;
         cnt++;
      end
      req = '0;
      chk("fair_cnt_ok", 8'(xfer_log.size() >= 16), 8'h01);
      for (int k = 0; k < 16; k++) begin
         if (k < xfer_log.size()) chk("fair_seq", xfer_log[k], 8'(1 << (k % 8)));
      end
      tick(20);

      // Overflow: two events on line 2 before it is granted
      do_reset();
      xfer_log.delete();
      req = 8'h04;
      tick(1);
      req = '0;
      tick(2);
      req = 8'h04;
      tick(1);
      req = '0;
      tick(5);
      @(negedge clk);
      chk("ovf_set", 8'(ovf), 8'h01);
      chk("ovf_d", d, 8'h04);
      @(posedge clk);
      #1;
      rdy = 1'b1;
      tick(6);
      @(negedge clk);
      chk("ovf_one_grant", 8'(xfer_log.size()), 8'd1);
      chk("ovf_pend", pend, 8'h00);
      chk("ovf_sticky", 8'(ovf), 8'h01);

      // Set wins: new event on line 3 lands on its acceptance edge
      do_reset();
      req = 8'h08;
      tick(1);
      req = '0;
      wait_vld(10);
      tick(1);
      req = 8'h08;
      tick(1);
      tick(1);
      rdy = 1'b1;
      tick(1);
      rdy = 1'b0;
      @(negedge clk);
      chk("sw_pend", pend, 8'h08);
      chk("sw_ovf", 8'(ovf), 8'h00);
      chk("sw_vld0", 8'(vld), 8'h00);
      @(negedge clk);
      chk("sw_vld1", 8'(vld), 8'h01);
      chk("sw_d", d, 8'h08);
      req = '0;
      @(posedge clk);
      #1;
      rdy = 1'b1;
      tick(4);

      // Asynchronous reset in the middle of a grant
      do_reset();
      req = 8'h80;
      tick(1);
      req = '0;
      wait_vld(10);
      chk("mid_d_pre", d, 8'h80);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_d", d, 8'h00);
      chk("mid_vld", 8'(vld), 8'h00);
      chk("mid_pend", pend, 8'h00);
      tick(2);
      rst_n = 1'b1;
      tick(3);

      // Random traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         nxt = '0;
         for (int b = 0; b < 8; b++) nxt[b] = ($urandom_range(9) == 0);
         req = req ^ nxt;
         rdy = ($urandom_range(2) != 0);
         tick(1);
      end
      req = '0;
      rdy = 1'b1;
      tick(40);
      @(negedge clk);
      chk("sb_drain", 8'(exp_q.size()), 8'(m_g));
      chk("end_pend", pend, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
